// File: rtl/pwm_multi.sv
// N-channel PWM with shared prescaler/period counter and double-buffered compares.
// Define PWM_CENTER_ALIGN_EN for an up/down (center-aligned) counter.
module pwm_multi #(
   parameter int CHANNELS     = 3,
   parameter int CTR_LEN      = 8,
   parameter int PRESCALE_LEN = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [PRESCALE_LEN-1:0]      prescale,
   input  logic [CTR_LEN-1:0]           top,
   input  logic [CHANNELS*CTR_LEN-1:0]  compare,
   input  logic                         load,
   output logic                         load_pending,
   output logic                         period_start,
   output logic [CHANNELS-1:0]          pwm
);

   localparam logic [CTR_LEN-1:0] ONE = CTR_LEN'(1);

   logic [PRESCALE_LEN-1:0]     presc_q, presc_d;
   logic [CTR_LEN-1:0]          ctr_q, ctr_d;
   logic [CHANNELS*CTR_LEN-1:0] pend_q, pend_d;
   logic [CHANNELS*CTR_LEN-1:0] act_q, act_d;
   logic                        lp_q, lp_d;
   logic                        ps_q, ps_d;
   logic [CHANNELS-1:0]         pwm_q, pwm_d;
   logic                        tick;
   logic                        wrap;
`ifdef PWM_CENTER_ALIGN_EN
   logic                        dir_q, dir_d;
`endif

   // Prescaler tick and period counter; wrap marks the tick that reloads 0
   always_comb begin
      tick    = (presc_q == prescale);
      presc_d = tick ? '0 : presc_q + 1'b1;
      ctr_d   = ctr_q;
      wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d   = dir_q;
      if (tick) begin
         if (!dir_q && ctr_q < top) begin
            ctr_d = ctr_q + ONE;
         end else if (ctr_q <= ONE) begin
            ctr_d = '0;
            dir_d = 1'b0;
            wrap  = 1'b1;
         end else begin
            ctr_d = ctr_q - ONE;
            dir_d = 1'b1;
         end
      end
`else
      if (tick) begin
         if (ctr_q >= top) begin
            ctr_d = '0;
            wrap  = 1'b1;
         end else begin
            ctr_d = ctr_q + ONE;
         end
      end
`endif
      if (!enable) begin
         presc_d = '0;
         ctr_d   = '0;
         wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_d   = 1'b0;
`endif
      end
   end

   // Compare double buffer: pending captures on load, active swaps at wrap
   always_comb begin
      pend_d = load ? compare : pend_q;
      act_d  = act_q;
      lp_d   = lp_q;
      if (!enable) begin
         act_d = pend_q;
         lp_d  = 1'b0;
      end else if (wrap) begin
         act_d = pend_d;
         lp_d  = 1'b0;
      end else if (load) begin
         lp_d  = 1'b1;
      end
      ps_d = wrap;
   end

   // Per-channel compare against the current counter value
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = enable & (act_q[i*CTR_LEN +: CTR_LEN] > ctr_q);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         ctr_q   <= '0;
         pend_q  <= '0;
         act_q   <= '0;
         lp_q    <= 1'b0;
         ps_q    <= 1'b0;
         pwm_q   <= '0;
      end else begin
         presc_q <= presc_d;
         ctr_q   <= ctr_d;
         pend_q  <= pend_d;
         act_q   <= act_d;
         lp_q    <= lp_d;
         ps_q    <= ps_d;
         pwm_q   <= pwm_d;
      end
   end

`ifdef PWM_CENTER_ALIGN_EN
   // Count direction, 0 = up
   always_ff @(posedge clk) begin
      if (rst) dir_q <= 1'b0;
      else     dir_q <= dir_d;
   end
`endif

   assign load_pending = lp_q;
   assign period_start = ps_q;
   assign pwm          = pwm_q;

endmodule
